// File: rtl/nfca_rx_frame_check.sv
// NFC-A RX frame checker: buffers one PICC frame, checks CRC_A, then
// replays it over a ready/valid stream with tlast and a status summary.
// Ports:
//   clk, rstn (sync, active-low), crc_en (sampled on first beat)
//   in_t*   : parser beats (valid/data/datab/end/err), no backpressure
//   m_t*    : output stream (valid/ready/data/datab/last)
//   st_*    : frame status pulse and held summary (len/crc_ok/col/err)
module nfca_rx_frame_check #(
  parameter int DEPTH = 64
) (
  input  logic                         rstn,
  input  logic                         clk,
  input  logic                         crc_en,
  input  logic                         in_tvalid,
  input  logic [7:0]                   in_tdata,
  input  logic [3:0]                   in_tdatab,
  input  logic                         in_tend,
  input  logic                         in_terr,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic [7:0]                   m_tdata,
  output logic [3:0]                   m_tdatab,
  output logic                         m_tlast,
  output logic                         st_valid,
  output logic [$clog2(DEPTH+1)-1:0]   st_len,
  output logic                         st_crc_ok,
  output logic                         st_col,
  output logic                         st_err
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_COLLECT,
    S_EVAL,
    S_DRAIN
  } state_t;

  state_t state, state_d;

  logic [7:0]    mem_d [DEPTH];
  logic [3:0]    mem_b [DEPTH];
  logic [LW-1:0] wr_ptr;
  logic [LW-1:0] rd_ptr;
  logic [15:0]   crc;
  logic          col;
  logic          err;
  logic          ovr;
  logic          started;
  logic          crc_en_q;

  logic          beat;
  logic          storable;
  logic          full;
  logic          wr_en;
  logic          is_col;
  logic          fold;
  logic          crc_ok_c;
  logic          err_c;
  logic          strip_c;
  logic [LW-1:0] len_c;
  logic          xfer;
  logic          drain_done;

  // Reflected CRC_A, one byte, LSB first.
  function automatic logic [15:0] crc_byte(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? 16'h8408 : 16'h0000);
    end
    return r;
  endfunction

  assign beat     = (state == S_COLLECT) && in_tvalid;
  assign storable = beat && (in_tdatab != 4'd0);
  assign full     = (wr_ptr == LW'(DEPTH));
  assign wr_en    = storable && !full;
  assign is_col   = beat && !in_tend &&
                    (in_tdatab != 4'd0) && (in_tdatab < 4'd8);
  assign fold     = wr_en && !in_tend && (in_tdatab == 4'd8);

  // Frame summary, valid while in EVAL.
  assign crc_ok_c = !crc_en_q ||
                    ((crc == 16'h0000) && (wr_ptr >= LW'(2)));
  assign err_c    = err || ovr || (wr_ptr == '0);
  assign strip_c  = crc_en_q && crc_ok_c && !col && !err_c;
  assign len_c    = strip_c ? (wr_ptr - LW'(2)) : wr_ptr;

  assign xfer       = m_tvalid && m_tready;
  assign drain_done = (state == S_DRAIN) &&
                      ((st_len == '0) || (xfer && m_tlast));

  always_comb begin
    state_d = state;
    unique case (state)
      S_COLLECT: if (beat && in_tend) state_d = S_EVAL;
      S_EVAL:    state_d = S_DRAIN;
      S_DRAIN:   if (drain_done) state_d = S_COLLECT;
      default:   state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= S_COLLECT;
    else       state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_d[wr_ptr[AW-1:0]] <= in_tdata;
      mem_b[wr_ptr[AW-1:0]] <= in_tdatab;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      crc       <= 16'h6363;
      col       <= 1'b0;
      err       <= 1'b0;
      ovr       <= 1'b0;
      started   <= 1'b0;
      crc_en_q  <= 1'b0;
      m_tvalid  <= 1'b0;
      m_tdata   <= '0;
      m_tdatab  <= '0;
      m_tlast   <= 1'b0;
      st_valid  <= 1'b0;
      st_len    <= '0;
      st_crc_ok <= 1'b0;
      st_col    <= 1'b0;
      st_err    <= 1'b0;
    end else begin
      st_valid <= 1'b0;
      unique case (state)
        S_COLLECT: begin
          if (beat) begin
            started <= 1'b1;
            if (!started) crc_en_q <= crc_en;
          end
          if (wr_en)             wr_ptr <= wr_ptr + LW'(1);
          if (storable && full)  err    <= 1'b1;
          if (is_col)            col    <= 1'b1;
          if (beat && in_tend && in_terr) err <= 1'b1;
          if (fold)              crc    <= crc_byte(crc, in_tdata);
        end
        S_EVAL: begin
          st_valid  <= 1'b1;
          st_len    <= len_c;
          st_crc_ok <= crc_ok_c;
          st_col    <= col;
          st_err    <= err_c;
          // Overrun already reported; only a beat now re-arms it.
          ovr       <= in_tvalid;
          if (len_c != '0) begin
            m_tvalid <= 1'b1;
            m_tdata  <= mem_d[0];
            m_tdatab <= mem_b[0];
            m_tlast  <= (len_c == LW'(1));
            rd_ptr   <= LW'(1);
          end
        end
        S_DRAIN: begin
          if (in_tvalid) ovr <= 1'b1;
          if (xfer) begin
            if (m_tlast) begin
              m_tvalid <= 1'b0;
              m_tlast  <= 1'b0;
            end else begin
              m_tdata  <= mem_d[rd_ptr[AW-1:0]];
              m_tdatab <= mem_b[rd_ptr[AW-1:0]];
              m_tlast  <= ((rd_ptr + LW'(1)) == st_len);
              rd_ptr   <= rd_ptr + LW'(1);
            end
          end
        end
        default: ;
      endcase
      // Fresh frame context whenever COLLECT is re-entered.
      if (drain_done) begin
        wr_ptr  <= '0;
        crc     <= 16'h6363;
        col     <= 1'b0;
        err     <= 1'b0;
        started <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nfca_rx_frame_check.sv
// Bench for nfca_rx_frame_check: directed frames plus random
// frames checked against a frame-level reference model.
module tb_nfca_rx_frame_check;

  localparam int DEPTH = 64;
  localparam int LW = $clog2(DEPTH + 1);

  logic          rstn, clk, crc_en;
  logic          in_tvalid, in_tend, in_terr;
  logic [7:0]    in_tdata;
  logic [3:0]    in_tdatab;
  logic          m_tvalid, m_tready, m_tlast;
  logic [7:0]    m_tdata;
  logic [3:0]    m_tdatab;
  logic          st_valid, st_crc_ok, st_col, st_err;
  logic [LW-1:0] st_len;

  nfca_rx_frame_check #(.DEPTH(DEPTH)) dut (
    .rstn(rstn), .clk(clk), .crc_en(crc_en),
    .in_tvalid(in_tvalid), .in_tdata(in_tdata),
    .in_tdatab(in_tdatab), .in_tend(in_tend),
    .in_terr(in_terr), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tdatab(m_tdatab), .m_tlast(m_tlast),
    .st_valid(st_valid), .st_len(st_len),
    .st_crc_ok(st_crc_ok), .st_col(st_col),
    .st_err(st_err)
  );

  initial clk = 1'b0;
  always #6 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [3:0] b;
    logic       e;
    logic       r;
  } beat_t;

  beat_t      fr[$];
  logic [7:0] exp_d[$];
  logic [3:0] exp_b[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         ovr_pend = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CRC_A over whole bytes, bytewise-xor formulation.
  function automatic logic [15:0] crc_a(input logic [7:0] q[$]);
    logic [15:0] c;
    c = 16'h6363;
    foreach (q[i]) begin
      c = c ^ {8'h00, q[i]};
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

  function automatic beat_t mk(input logic [7:0] d,
                               input logic [3:0] b,
                               input logic e, input logic r);
    beat_t t;
    t.d = d; t.b = b; t.e = e; t.r = r;
    return t;
  endfunction

  task automatic push_bytes(input logic [7:0] q[$]);
    foreach (q[i]) fr.push_back(mk(q[i], 4'd8, 1'b0, 1'b0));
  endtask

  task automatic idle_inputs();
    in_tvalid = 0; in_tdata = 0; in_tdatab = 0;
    in_tend = 0; in_terr = 0;
  endtask

  // Model the frame, send it, and check status and latency.
  task automatic send_status(input bit cen, input bit gaps);
    logic [7:0] sd[$];
    logic [3:0] sb[$];
    logic [7:0] fb[$];
    bit col, err, ok, strip;
    int n, lat;
    col = 0;
    err = ovr_pend;
    ovr_pend = 0;
    foreach (fr[i]) begin
      if (fr[i].b != 0) begin
        if (sd.size() < DEPTH) begin
          sd.push_back(fr[i].d);
          sb.push_back(fr[i].b);
          if (fr[i].b == 8 && !fr[i].e) fb.push_back(fr[i].d);
        end else err = 1;
      end
      if (!fr[i].e && fr[i].b >= 1 && fr[i].b <= 7) col = 1;
      if (fr[i].e && fr[i].r) err = 1;
    end
    if (sd.size() == 0) err = 1;
    ok = !cen || (sd.size() >= 2 && crc_a(fb) == 16'h0);
    strip = cen && ok && !col && !err;
    n = sd.size() - (strip ? 2 : 0);
    exp_d.delete();
    exp_b.delete();
    for (int i = 0; i < n; i++) begin
      exp_d.push_back(sd[i]);
      exp_b.push_back(sb[i]);
    end
    foreach (fr[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        idle_inputs();
      end
      @(negedge clk);
      crc_en    = (i == 0) ? cen : !cen;
      in_tvalid = 1;
      in_tdata  = fr[i].d;
      in_tdatab = fr[i].b;
      in_tend   = fr[i].e;
      in_terr   = fr[i].r;
    end
    lat = 0;
    do begin
      @(negedge clk);
      idle_inputs();
      lat++;
    end while (!st_valid && lat < 10);
    chk("latency", lat, 2);
    chk("st_len", st_len, n);
    chk("st_crc_ok", st_crc_ok, ok);
    chk("st_col", st_col, col);
    chk("st_err", st_err, err);
  endtask

  task automatic drain(input bit rnd, input bit inj);
    int  got, guard, n;
    bit  done, stall;
    logic [7:0] hd;
    logic [3:0] hb;
    logic hl;
    n = exp_d.size();
    got = 0; guard = 0; done = 0; stall = 0;
    hd = 0; hb = 0; hl = 0;
    if (n == 0) begin
      chk("empty_tvalid", m_tvalid, 0);
      @(negedge clk);
      chk("empty_pulse", st_valid, 0);
      chk("empty_tvalid2", m_tvalid, 0);
      return;
    end
    while (!done && guard < 4000) begin
      if (guard == 1) chk("st_pulse", st_valid, 0);
      chk("tvalid", m_tvalid, 1);
      if (stall) begin
        chk("hold_data", m_tdata, hd);
        chk("hold_bits", m_tdatab, hb);
        chk("hold_last", m_tlast, hl);
      end
      m_tready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_tvalid = inj && guard == 0;
      if (m_tvalid && m_tready) begin
        if (got < n) begin
          chk("data", m_tdata, exp_d[got]);
          chk("bits", m_tdatab, exp_b[got]);
          chk("last", m_tlast, got == n - 1);
        end else chk("extra_byte", got, n);
        if (m_tlast) done = 1;
        got++;
        stall = 0;
      end else begin
        stall = m_tvalid;
        hd = m_tdata; hb = m_tdatab; hl = m_tlast;
      end
      @(negedge clk);
      in_tvalid = 0;
      guard++;
    end
    if (inj) ovr_pend = 1;
    chk("byte_count", got, n);
    chk("tvalid_after", m_tvalid, 0);
  endtask

  task automatic run_frame(input bit cen, input bit rnd,
                           input bit gaps, input bit inj);
    send_status(cen, gaps);
    drain(rnd, inj);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [15:0] c;
    bit cen;
    int n, kind;
    rstn = 0; crc_en = 0; m_tready = 0;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_st_valid", st_valid, 0);
    chk("rst_st_len", st_len, 0);
    chk("rst_st_err", st_err, 0);
    chk("rst_st_crc_ok", st_crc_ok, 0);
    rstn = 1;
    @(negedge clk);

    // ATQA, no CRC
    fr.delete();
    q = '{8'h44, 8'h00}; push_bytes(q);
    fr.push_back(mk(8'h00, 4'd0, 1'b1, 1'b0));
    run_frame(0, 0, 0, 0);

    // HLTA with good CRC: stripped
    fr.delete();
    q = '{8'h50, 8'h00, 8'h57, 8'hCD}; push_bytes(q);
    fr.push_back(mk(8'h00, 4'd0, 1'b1, 1'b0));
    run_frame(1, 0, 0, 0);
    chk("hlta_len", st_len, 2);

    // HLTA with bad CRC: all 4 bytes kept
    fr.delete();
    q = '{8'h50, 8'h00, 8'h57, 8'hCC}; push_bytes(q);
    fr.push_back(mk(8'h00, 4'd0, 1'b1, 1'b0));
    run_frame(1, 0, 0, 0);
    chk("hlta_bad_len", st_len, 4);

    // Anticollision with collision byte
    fr.delete();
    q = '{8'h93, 8'h20}; push_bytes(q);
    fr.push_back(mk(8'h05, 4'd3, 1'b0, 1'b0));
    fr.push_back(mk(8'h00, 4'd0, 1'b1, 1'b0));
    run_frame(1, 0, 0, 0);

    // Overflow, random ready
    fr.delete();
    for (int i = 0; i < DEPTH + 3; i++)
      fr.push_back(mk(8'($urandom), 4'd8, 1'b0, 1'b0));
    fr.push_back(mk(8'h00, 4'd0, 1'b1, 1'b0));
    run_frame(0, 1, 0, 0);
    chk("ovf_len", st_len, DEPTH);

    // Error beat carrying data
    fr.delete();
    fr.push_back(mk(8'hA5, 4'd8, 1'b0, 1'b0));
    fr.push_back(mk(8'h1C, 4'd5, 1'b1, 1'b1));
    run_frame(0, 0, 0, 0);

    // Empty frame
    fr.delete();
    fr.push_back(mk(8'h00, 4'd0, 1'b1, 1'b0));
    run_frame(1, 0, 0, 0);

    // Overrun during drain, reported on next frame
    fr.delete();
    q = '{8'h11, 8'h22, 8'h33}; push_bytes(q);
    fr.push_back(mk(8'h00, 4'd0, 1'b1, 1'b0));
    run_frame(0, 0, 0, 1);
    fr.delete();
    q = '{8'h44, 8'h00}; push_bytes(q);
    fr.push_back(mk(8'h00, 4'd0, 1'b1, 1'b0));
    run_frame(0, 0, 0, 0);
    fr.delete();
    push_bytes(q);
    fr.push_back(mk(8'h00, 4'd0, 1'b1, 1'b0));
    run_frame(0, 0, 0, 0);

    // Reset mid-drain
    fr.delete();
    q = '{8'h44, 8'h00}; push_bytes(q);
    fr.push_back(mk(8'h00, 4'd0, 1'b1, 1'b0));
    m_tready = 0;
    send_status(0, 0);
    chk("mid_tvalid", m_tvalid, 1);
    rstn = 0;
    @(negedge clk);
    chk("rst_drain_tvalid", m_tvalid, 0);
    chk("rst_drain_tlast", m_tlast, 0);
    rstn = 1;
    ovr_pend = 0;
    fr.delete();
    q = '{8'h50, 8'h00, 8'h57, 8'hCD}; push_bytes(q);
    fr.push_back(mk(8'h00, 4'd0, 1'b1, 1'b0));
    run_frame(1, 0, 0, 0);

    // Random frames
    for (int t = 0; t < 60; t++) begin
      fr.delete();
      q.delete();
      cen = 1'($urandom_range(0, 1));
      n = $urandom_range(0, 10);
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      if (cen && $urandom_range(0, 3) != 0) begin
        c = crc_a(q);
        q.push_back(c[7:0]);
        q.push_back(c[15:8]);
        if ($urandom_range(0, 3) == 0) begin
          n = $urandom_range(0, q.size() - 1);
          q[n] = q[n] ^ 8'(1 << $urandom_range(0, 7));
        end
      end
      push_bytes(q);
      kind = $urandom_range(0, 5);
      if (kind == 0) begin
        fr.push_back(mk(8'($urandom),
                        4'($urandom_range(1, 7)), 1'b0, 1'b0));
        fr.push_back(mk(8'h00, 4'd0, 1'b1, 1'b0));
      end else if (kind == 1) begin
        fr.push_back(mk(8'($urandom),
                        4'($urandom_range(0, 8)), 1'b1, 1'b1));
      end else begin
        fr.push_back(mk(8'h00, 4'd0, 1'b1, 1'b0));
      end
      run_frame(cen, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
